// File: rtl/nc_pkg.sv
// Shared constants and types for the neuromorphic step sequencer.
// Opcodes follow the 8-bit A control-word format: A[7:5] opcode, A[4:0] index.
package nc_pkg;

    localparam logic [2:0] NC_OP_NOP      = 3'b111;
    localparam logic [2:0] NC_OP_SRC_H    = 3'b011;
    localparam logic [2:0] NC_OP_SRC_A    = 3'b100;
    localparam logic [2:0] NC_OP_NSR_WR_H = 3'b011;
    localparam logic [2:0] NC_OP_NSR_WR_A = 3'b100;

    // Opcode 000 is a write, so the idle word must carry the NOP opcode.
    localparam logic [7:0] NC_IDLE_A = {NC_OP_NOP, 5'b0};

    typedef enum logic [1:0] {
        NC_CMD_CONVH = 2'b00,
        NC_CMD_CONVA = 2'b01,
        NC_CMD_ILL2  = 2'b10,
        NC_CMD_ILL3  = 2'b11
    } nc_cmd_op_e;

    typedef enum logic [2:0] {
        NC_ST_IDLE  = 3'd0,
        NC_ST_FETCH = 3'd1,
        NC_ST_ACC   = 3'd2,
        NC_ST_WB    = 3'd3,
        NC_ST_DONE  = 3'd4
    } nc_seq_state_e;

    function automatic logic nc_op_legal(input nc_cmd_op_e op);
        return (op == NC_CMD_CONVH) || (op == NC_CMD_CONVA);
    endfunction

endpackage

// File: rtl/nc_step_sequencer_if.sv
// Command handshake between instruction decode (master) and the step sequencer (slave).
interface nc_step_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_wreg;
    logic [3:0] cmd_sreg;
    logic [3:0] cmd_nreg;

    modport master (
        output cmd_valid, cmd_op, cmd_wreg, cmd_sreg, cmd_nreg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wreg, cmd_sreg, cmd_nreg,
        output cmd_ready
    );
endinterface

// File: rtl/nc_perf_counter.sv
// Free-running wrap-around event counter with increment enable.
module nc_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/nc_step_sequencer.sv
// Sequences one synaptic-accumulate step: fetch, accumulate, write back, done.
// Optional cmd_count performance counter is enabled by defining NC_SEQ_PERF_EN.
module nc_step_sequencer
    import nc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    nc_step_sequencer_if.slave   cmd,
    output logic [7:0]           wvr_a,
    output logic [7:0]           svr_a,
    output logic [7:0]           nsr_a,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
`ifdef NC_SEQ_PERF_EN
    ,
    output logic [31:0]          cmd_count
`endif
);
    nc_seq_state_e state_q, state_d;
    nc_cmd_op_e    op_q, op_d;
    logic [3:0]    wreg_q, wreg_d, sreg_q, sreg_d, nreg_q, nreg_d;
    logic          err_q, err_d;
    logic [7:0]    wvr_a_q, wvr_a_d, svr_a_q, svr_a_d, nsr_a_q, nsr_a_d;
    logic          busy_q, busy_d, done_q, done_d, cmd_err_q, cmd_err_d;
    logic          accept;
    logic          conva;

    assign cmd.cmd_ready = (state_q == NC_ST_IDLE);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wreg_d  = wreg_q;
        sreg_d  = sreg_q;
        nreg_d  = nreg_q;
        err_d   = err_q;
        case (state_q)
            NC_ST_IDLE: begin
                if (accept) begin
                    op_d    = nc_cmd_op_e'(cmd.cmd_op);
                    wreg_d  = cmd.cmd_wreg;
                    sreg_d  = cmd.cmd_sreg;
                    nreg_d  = cmd.cmd_nreg;
                    err_d   = !nc_op_legal(op_d);
                    state_d = err_d ? NC_ST_DONE : NC_ST_FETCH;
                end
            end
            NC_ST_FETCH: state_d = NC_ST_ACC;
            NC_ST_ACC:   state_d = NC_ST_WB;
            NC_ST_WB:    state_d = NC_ST_DONE;
            NC_ST_DONE:  state_d = NC_ST_IDLE;
            default:     state_d = NC_ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state's cycle.
    always_comb begin
        conva   = (op_d == NC_CMD_CONVA);
        wvr_a_d = NC_IDLE_A;
        svr_a_d = NC_IDLE_A;
        nsr_a_d = NC_IDLE_A;
        case (state_d)
            NC_ST_FETCH: begin
                // conva sources the whole weight file, so its index is zero.
                wvr_a_d = conva ? {NC_OP_SRC_A, 5'b0} : {NC_OP_SRC_H, 1'b0, wreg_d};
                svr_a_d = {(conva ? NC_OP_SRC_A : NC_OP_SRC_H), 1'b0, sreg_d};
            end
            NC_ST_WB: begin
                nsr_a_d = conva ? {NC_OP_NSR_WR_A, 5'b0} : {NC_OP_NSR_WR_H, 1'b0, nreg_d};
            end
            default: ;
        endcase
        busy_d    = (state_d != NC_ST_IDLE);
        done_d    = (state_d == NC_ST_DONE);
        cmd_err_d = done_d && err_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= NC_ST_IDLE;
            op_q      <= NC_CMD_CONVH;
            wreg_q    <= '0;
            sreg_q    <= '0;
            nreg_q    <= '0;
            err_q     <= 1'b0;
            wvr_a_q   <= NC_IDLE_A;
            svr_a_q   <= NC_IDLE_A;
            nsr_a_q   <= NC_IDLE_A;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wreg_q    <= wreg_d;
            sreg_q    <= sreg_d;
            nreg_q    <= nreg_d;
            err_q     <= err_d;
            wvr_a_q   <= wvr_a_d;
            svr_a_q   <= svr_a_d;
            nsr_a_q   <= nsr_a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign wvr_a   = wvr_a_q;
    assign svr_a   = svr_a_q;
    assign nsr_a   = nsr_a_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cmd_err = cmd_err_q;

`ifdef NC_SEQ_PERF_EN
    nc_perf_counter #(.W(32)) u_perf (
        .clk    (clk),
        .reset  (reset),
        .inc_en ((state_q == NC_ST_DONE) && !err_q),
        .count  (cmd_count)
    );
`endif
endmodule

// File: tb/tb_nc_step_sequencer.sv
// Self-checking bench for nc_step_sequencer: vector table, hand sequences, random vs reference model.
module tb_nc_step_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] wvr_a, svr_a, nsr_a;
    logic busy, done, cmd_err;
`ifdef NC_SEQ_PERF_EN
    logic [31:0] cmd_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    nc_step_sequencer_if cmd();

    nc_step_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .cmd     (cmd),
        .wvr_a   (wvr_a),
        .svr_a   (svr_a),
        .nsr_a   (nsr_a),
        .busy    (busy),
        .done    (done),
        .cmd_err (cmd_err)
`ifdef NC_SEQ_PERF_EN
        ,
        .cmd_count (cmd_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] w, s, n;
        logic [7:0] ew, es, en;
        logic       err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".ready"}, cmd.cmd_ready, 1);
        chk({nm, ".busy"}, busy, 0);
        chk({nm, ".done"}, done, 0);
        chk({nm, ".err"}, cmd_err, 0);
        chk({nm, ".wvr"}, wvr_a, 8'hE0);
        chk({nm, ".svr"}, svr_a, 8'hE0);
        chk({nm, ".nsr"}, nsr_a, 8'hE0);
`ifdef NC_SEQ_PERF_EN
        chk({nm, ".count"}, cmd_count, exp_count);
`endif
    endtask

    // Reference: what the three control words must be in the fetch and write-back phases.
    function automatic vec_t model(input logic [1:0] op, input logic [3:0] w, s, n);
        vec_t v;
        v.op = op; v.w = w; v.s = s; v.n = n;
        v.err = (op > 2'd1);
        v.ew = 8'hE0; v.es = 8'hE0; v.en = 8'hE0;
        if (op == 2'd0) begin
            v.ew = 8'h60 + 8'(w);
            v.es = 8'h60 + 8'(s);
            v.en = 8'h60 + 8'(n);
        end else if (op == 2'd1) begin
            v.ew = 8'h80;
            v.es = 8'h80 + 8'(s);
            v.en = 8'h80;
        end
        return v;
    endfunction

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_cmd(input string nm, input vec_t v);
        int len;
        logic [7:0] xw, xs, xn;
        len = v.err ? 1 : 4;
        chk({nm, ".ready0"}, cmd.cmd_ready, 1);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op    = v.op;
        cmd.cmd_wreg  = v.w;
        cmd.cmd_sreg  = v.s;
        cmd.cmd_nreg  = v.n;
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op    = 2'($urandom);
        cmd.cmd_wreg  = 4'($urandom);
        cmd.cmd_sreg  = 4'($urandom);
        cmd.cmd_nreg  = 4'($urandom);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            xw = (!v.err && c == 1) ? v.ew : 8'hE0;
            xs = (!v.err && c == 1) ? v.es : 8'hE0;
            xn = (!v.err && c == 3) ? v.en : 8'hE0;
            chk($sformatf("%s.c%0d.wvr", nm, c), wvr_a, xw);
            chk($sformatf("%s.c%0d.svr", nm, c), svr_a, xs);
            chk($sformatf("%s.c%0d.nsr", nm, c), nsr_a, xn);
            chk($sformatf("%s.c%0d.busy", nm, c), busy, 1);
            chk($sformatf("%s.c%0d.ready", nm, c), cmd.cmd_ready, 0);
            chk($sformatf("%s.c%0d.done", nm, c), done, (c == len));
            chk($sformatf("%s.c%0d.err", nm, c), cmd_err, (c == len) && v.err);
        end
        if (!v.err) exp_count++;
        @(negedge clk);
        chk_idle({nm, ".after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int acc_cyc[$];
        int done_cyc[$];

        tbl[0] = '{2'd0, 4'd2,  4'd5,  4'd9,  8'h62, 8'h65, 8'h69, 1'b0};
        tbl[1] = '{2'd1, 4'd1,  4'd3,  4'd4,  8'h80, 8'h83, 8'h80, 1'b0};
        tbl[2] = '{2'd2, 4'd2,  4'd5,  4'd9,  8'hE0, 8'hE0, 8'hE0, 1'b1};
        tbl[3] = '{2'd3, 4'd7,  4'd7,  4'd7,  8'hE0, 8'hE0, 8'hE0, 1'b1};
        tbl[4] = '{2'd0, 4'd15, 4'd15, 4'd15, 8'h6F, 8'h6F, 8'h6F, 1'b0};
        tbl[5] = '{2'd1, 4'd7,  4'd0,  4'd15, 8'h80, 8'h80, 8'h80, 1'b0};
        tbl[6] = '{2'd0, 4'd0,  4'd0,  4'd0,  8'h60, 8'h60, 8'h60, 1'b0};
        tbl[7] = '{2'd1, 4'd15, 4'd15, 4'd0,  8'h80, 8'h8F, 8'h80, 1'b0};

        cmd.cmd_valid = 1'b0;
        cmd.cmd_op = 2'd0; cmd.cmd_wreg = 4'd0; cmd.cmd_sreg = 4'd0; cmd.cmd_nreg = 4'd0;

        // Reset state, then ten idle cycles with valid low.
        @(negedge clk); @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle%0d", i));
        end

        foreach (tbl[i]) run_cmd($sformatf("tbl%0d", i), tbl[i]);

        // Valid held high: accepts at cycles 0, 5, 10; DONE cycles do not accept.
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op = 2'd0; cmd.cmd_wreg = 4'd1; cmd.cmd_sreg = 4'd2; cmd.cmd_nreg = 4'd3;
        for (int cyc = 0; cyc < 15; cyc++) begin
            if (cmd.cmd_ready && cmd.cmd_valid) acc_cyc.push_back(cyc);
            if (done) done_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (acc_cyc.size() == 3) cmd.cmd_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b.acc_n", acc_cyc.size(), 3);
        foreach (acc_cyc[i]) chk($sformatf("b2b.acc%0d", i), acc_cyc[i], 5 * i);
        chk("b2b.done_n", done_cyc.size(), 3);
        foreach (done_cyc[i]) chk($sformatf("b2b.done%0d", i), done_cyc[i], 5 * i + 4);
        exp_count += 3;
        chk_idle("b2b.after");

        // Reset in cycle 2 of a convh: the write-back must never appear.
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op = 2'd0; cmd.cmd_wreg = 4'd2; cmd.cmd_sreg = 4'd5; cmd.cmd_nreg = 4'd9;
        @(posedge clk); #1;
        cmd.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst.c1.wvr", wvr_a, 8'h62);
        @(negedge clk);
        chk("rst.c2.busy", busy, 1);
        reset = 1'b1;
        exp_count = 0;
        #1;
        chk("rst.async.busy", busy, 0);
        chk("rst.async.ready", cmd.cmd_ready, 1);
        @(negedge clk);
        chk("rst.c3.nsr", nsr_a, 8'hE0);
        chk("rst.c3.done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_idle($sformatf("rst.post%0d", i));
        end

        // Randomized commands with random idle gaps against the reference model.
        for (int i = 0; i < 40; i++) begin
            v = model(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            run_cmd($sformatf("rnd%0d", i), v);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                cmd.cmd_op = 2'($urandom);
                @(negedge clk);
                chk_idle($sformatf("rnd%0d.gap%0d", i, g));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
